// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants for the multi-port register file
package regfile_mp_pkg;

  localparam int          XLEN         = 32;
  localparam int          REG_NUM      = 32;
  localparam int          REG_NUM_LOG2 = $clog2(REG_NUM);
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        READ_ENABLE  = 1'b1;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ACTIVE   = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port with write-through bypass and busy lookup
module regfile_rd_port #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NWR  = 1
) (
  input  logic [AW-1:0]       raddr_i,
  input  logic                re_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0]     regs_i [NREG],
  input  logic [NREG-1:0]     busy_i,
  output logic [XLEN-1:0]     rdata_o,
  output logic                rbusy_o
);
  import regfile_mp_pkg::*;

  logic            hit;
  logic [XLEN-1:0] byp_data;

  // Later ports overwrite earlier matches, so the highest-index writer wins.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k] == WRITE_ENABLE && waddr_i[k*AW +: AW] == raddr_i) begin
        hit      = 1'b1;
        byp_data = wdata_i[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (re_i == READ_ENABLE && raddr_i != '0) begin
      if (hit) begin
        rdata_o = byp_data;
      end else begin
        rdata_o = regs_i[raddr_i];
        rbusy_o = busy_i[raddr_i];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with busy scoreboard
module regfile_mp #(
  parameter int XLEN = regfile_mp_pkg::XLEN,
  parameter int NREG = regfile_mp_pkg::REG_NUM,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);
  import regfile_mp_pkg::*;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NRD-1:0]  re_eff;

  // Bypass data would otherwise leak through while reset is held.
  assign re_eff = re & {NRD{rst != RST_ACTIVE}};

  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] == WRITE_ENABLE && waddr[k*AW +: AW] != '0) begin
        regs_d[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Assignment order encodes priority: flush > alloc > writeback > hold.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] == WRITE_ENABLE && waddr[k*AW +: AW] == AW'(i)) begin
          busy_d[i] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr == AW'(i)) begin
        busy_d[i] = 1'b1;
      end
      if (flush) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    regfile_rd_port #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW),
      .NWR  (NWR)
    ) u_rd_port (
      .raddr_i (raddr[j*AW +: AW]),
      .re_i    (re_eff[j]),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .regs_i  (regs_q),
      .busy_i  (busy_q),
      .rdata_o (rdata[j*XLEN +: XLEN]),
      .rbusy_o (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [NREG-1:0]     busy_vec;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .busy_vec(busy_vec)
  );

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [NREG-1:0] model_busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Read semantics straight from the rules: disabled/x0 -> 0, newest same-cycle write, else stored.
  task automatic check_reads(input string tag);
    for (int j = 0; j < NRD; j++) begin
      int a;
      logic [XLEN-1:0] ed;
      logic eb;
      a  = int'(raddr[j*AW +: AW]);
      ed = '0;
      eb = 1'b0;
      if (rst && re[j] && a != 0) begin
        bit written = 0;
        ed = m_regs[a];
        for (int k = 0; k < NWR; k++)
          if (we[k] && int'(waddr[k*AW +: AW]) == a) begin
            written = 1;
            ed = wdata[k*XLEN +: XLEN];
          end
        eb = written ? 1'b0 : m_busy[a];
      end
      check_eq($sformatf("%s_rdata%0d", tag, j), 64'(rdata[j*XLEN +: XLEN]), 64'(ed));
      check_eq($sformatf("%s_rbusy%0d", tag, j), 64'(rbusy[j]), 64'(eb));
    end
  endtask

  task automatic model_clock();
    bit written [NREG];
    if (!rst) return;
    for (int i = 0; i < NREG; i++) written[i] = 0;
    for (int k = 0; k < NWR; k++) begin
      int a = int'(waddr[k*AW +: AW]);
      if (we[k] && a != 0) begin
        m_regs[a] = wdata[k*XLEN +: XLEN];
        written[a] = 1;
      end
    end
    for (int i = 1; i < NREG; i++) begin
      if (flush) m_busy[i] = 1'b0;
      else if (alloc_en && int'(alloc_addr) == i) m_busy[i] = 1'b1;
      else if (written[i]) m_busy[i] = 1'b0;
    end
  endtask

  // Entered just after a negedge with inputs applied; leaves at the next negedge.
  task automatic cycle(input string tag);
    #1;
    check_reads(tag);
    model_clock();
    @(posedge clk);
    #1;
    check_eq({tag, "_busy_vec"}, 64'(busy_vec), 64'(model_busy_vec()));
    @(negedge clk);
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input int k, input int a, input logic [XLEN-1:0] d);
    we[k] = 1'b1;
    waddr[k*AW +: AW] = AW'(a);
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int j, input int a);
    re[j] = 1'b1;
    raddr[j*AW +: AW] = AW'(a);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #12;
    check_eq("reset_busy_vec", 64'(busy_vec), 64'd0);
    set_rd(0, 5);
    #1;
    check_eq("reset_rdata0", 64'(rdata[XLEN-1:0]), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Mid-run asynchronous reset
    set_wr(0, 5, 32'hDEADBEEF); alloc_en = 1'b1; alloc_addr = 5;
    cycle("wr_x5");
    idle(); set_rd(0, 5); set_wr(1, 5, 32'h0000_0001); alloc_en = 1'b1; alloc_addr = 6;
    #1;
    check_eq("pre_rst_rdata0", 64'(rdata[XLEN-1:0]), 64'h1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("in_rst_rdata0", 64'(rdata[XLEN-1:0]), 64'd0);
    check_eq("in_rst_rbusy0", 64'(rbusy[0]), 64'd0);
    check_eq("in_rst_busy_vec", 64'(busy_vec), 64'd0);
    @(posedge clk); #1;
    check_eq("in_rst_busy_vec2", 64'(busy_vec), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(); set_rd(0, 5);
    cycle("post_rst_x5");

    // x0 hardwired
    idle(); set_wr(0, 0, 32'h1234); set_wr(1, 0, 32'h1234);
    alloc_en = 1'b1; alloc_addr = 0; set_rd(0, 0); set_rd(1, 0);
    cycle("x0");

    // Same-address write priority with bypass
    idle(); set_wr(0, 3, 32'hAAAA0000); set_wr(1, 3, 32'h5555FFFF); set_rd(0, 3);
    #1;
    check_eq("x3_bypass", 64'(rdata[XLEN-1:0]), 64'h5555FFFF);
    #0;
    cycle("x3_wr");
    idle(); set_rd(0, 3); set_rd(1, 3);
    #1;
    check_eq("x3_stored", 64'(rdata[XLEN +: XLEN]), 64'h5555FFFF);
    cycle("x3_rd");

    // Allocate then writeback x7
    idle(); alloc_en = 1'b1; alloc_addr = 7;
    cycle("x7_alloc");
    idle(); set_rd(0, 7);
    check_eq("x7_busy_bit", 64'(busy_vec[7]), 64'd1);
    cycle("x7_busy_rd");
    idle(); set_rd(0, 7); set_wr(0, 7, 32'h0000_0042);
    cycle("x7_wb");
    check_eq("x7_cleared", 64'(busy_vec[7]), 64'd0);

    // Alloc + writeback same cycle keeps busy; flush overrides alloc
    idle(); alloc_en = 1'b1; alloc_addr = 9;
    cycle("x9_alloc");
    idle(); alloc_en = 1'b1; alloc_addr = 9; set_wr(1, 9, 32'h99);
    cycle("x9_alloc_wb");
    check_eq("x9_still_busy", 64'(busy_vec[9]), 64'd1);
    idle(); flush = 1'b1; alloc_en = 1'b1; alloc_addr = 10;
    cycle("flush_alloc");
    check_eq("flush_all_clear", 64'(busy_vec), 64'd0);

    // Disabled read port
    idle(); set_wr(0, 4, 32'hFFFF_FFFF);
    cycle("x4_wr");
    idle(); set_rd(0, 4); raddr[AW +: AW] = AW'(4);
    cycle("x4_re1_off");

    // Random traffic; narrow address range half the time to force collisions
    for (int n = 0; n < 3000; n++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 7 : NREG - 1;
      idle();
      for (int k = 0; k < NWR; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        waddr[k*AW +: AW] = AW'($urandom_range(0, hi));
        wdata[k*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRD; j++) begin
        re[j] = ($urandom_range(0, 7) != 0);
        raddr[j*AW +: AW] = AW'($urandom_range(0, hi));
      end
      alloc_en   = 1'($urandom_range(0, 1));
      alloc_addr = AW'($urandom_range(0, hi));
      flush      = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
